// File: rtl/cadder_pkg.sv
// Shared types and helpers for the cadder sweep checker.
package cadder_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  // Number of operand pairs swept for a given operand width.
  function automatic int unsigned n_vec(input int unsigned width);
    return 32'd1 << (2 * width);
  endfunction

  // Reference sum of two operands, reduced modulo 2^(width+1).
  function automatic int unsigned expected_sum(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned width);
    int unsigned mask;
    mask = (32'd1 << (width + 1)) - 32'd1;
    return (a + b) & mask;
  endfunction

endpackage

// File: rtl/cadder_chk_delay.sv
// Valid-tagged shift register that aligns launched vectors with the DUT's Z.
module cadder_chk_delay #(
  parameter int DEPTH = 2,
  parameter int PW    = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  output logic [PW-1:0] out_data
);

  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    data [DEPTH];

  // Shift one stage per clock; reset empties every stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= '0;
    end else begin
      vld[0]  <= in_valid;
      data[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i]  <= vld[i-1];
        data[i] <= data[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = data[DEPTH-1];

endmodule

// File: rtl/cadder_checker.sv
// Exhaustive A/B sweep engine for a cadder: launches every operand pair,
// compares the returned Z against A+B after LATENCY+1 clocks, and records
// the error count and the first failing vector.
// Handshake: start is a one-cycle request honoured only in IDLE or DONE;
// busy is high while vectors are in flight (RUN/DRAIN); done holds until
// the next accepted start.
module cadder_checker
  import cadder_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1,
  parameter int ERR_W   = 2*WIDTH+1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH:0]   Z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH:0]   first_err_z,
  output logic [1:0]       dbg_state
);

  localparam int VW = 2*WIDTH;
  localparam int EW = WIDTH+1;
  localparam int PW = 3*WIDTH+1;

  chk_state_t       state, next_state;
  logic [VW-1:0]    vec;
  logic [2:0]       drain_cnt;
  logic             launch;
  logic             start_sweep;
  logic [EW-1:0]    exp_in;
  logic [PW-1:0]    dl_in;
  logic [PW-1:0]    dl_out;
  logic             dl_valid;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic [EW-1:0]    cmp_exp;
  logic             mismatch;

  assign launch      = (state == RUN);
  assign start_sweep = start && ((state == IDLE) || (state == DONE));
  assign exp_in      = EW'(expected_sum(32'(vec[VW-1:WIDTH]), 32'(vec[WIDTH-1:0]), WIDTH));
  assign dl_in       = {vec, exp_in};
  assign {cmp_a, cmp_b, cmp_exp} = dl_out;
  assign mismatch    = dl_valid && (Z != cmp_exp);

  // Each launched vector travels with its expected sum until its Z arrives.
  cadder_chk_delay #(
    .DEPTH (LATENCY+1),
    .PW    (PW)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (launch),
    .in_data   (dl_in),
    .out_valid (dl_valid),
    .out_data  (dl_out)
  );

  // Next-state decode for the sweep controller.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (vec == '1) next_state = DRAIN;
      DRAIN:   if (drain_cnt == 3'(LATENCY)) next_state = DONE;
      DONE:    if (start) next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  // State register, vector counter, operand launch and drain timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      drain_cnt <= '0;
      A         <= '0;
      B         <= '0;
    end else begin
      state <= next_state;
      if (start_sweep) begin
        vec       <= '0;
        drain_cnt <= '0;
      end
      if (launch) begin
        A   <= vec[VW-1:WIDTH];
        B   <= vec[WIDTH-1:0];
        vec <= vec + VW'(1);
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 3'd1;
    end
  end

  // Error accounting: saturating count plus a one-shot capture of the first miss.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_z     <= '0;
    end else if (start_sweep) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_a     <= '0;
      first_err_b     <= '0;
      first_err_z     <= '0;
    end else if (mismatch) begin
      if (err_count != '1) err_count <= err_count + ERR_W'(1);
      if (!first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_a     <= cmp_a;
        first_err_b     <= cmp_b;
        first_err_z     <= Z;
      end
    end
  end

  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign pass      = done && (err_count == '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_cadder_checker.sv
// Bench for cadder_checker: a fault-injectable 1-stage adder model feeds a
// LATENCY=1 checker, and an ideal 1-stage adder feeds a LATENCY=2 checker.
module tb_cadder_checker;

  localparam int W  = 4;
  localparam int NV = 1 << (2*W);
  localparam int L1 = 1;
  localparam int L2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           start1, start2;
  logic [W-1:0]   a1, b1, a2, b2;
  logic [W:0]     z1, z2;
  logic           busy1, done1, pass1, fev1;
  logic           busy2, done2, pass2, fev2;
  logic [2*W:0]   err1, err2;
  logic [W-1:0]   fa1, fb1, fa2, fb2;
  logic [W:0]     fz1, fz2;
  logic [1:0]     st1, st2;

  logic [W:0]     fault [NV];
  logic [2*W-1:0] exp_q[$];
  int             n_checks = 0;
  int             n_pass   = 0;

  cadder_checker #(.WIDTH(W), .LATENCY(L1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Z(z1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fev1), .first_err_a(fa1), .first_err_b(fb1),
    .first_err_z(fz1), .dbg_state(st1)
  );

  cadder_checker #(.WIDTH(W), .LATENCY(L2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2), .Z(z2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_valid(fev2), .first_err_a(fa2), .first_err_b(fb2),
    .first_err_z(fz2), .dbg_state(st2)
  );

  // One-register adders standing in for the cadder; dut1's can corrupt Z.
  always @(posedge clk) begin
    z1 <= ({1'b0, a1} + {1'b0, b1}) ^ fault[{a1, b1}];
    z2 <= {1'b0, a2} + {1'b0, b2};
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int sum_of(input int idx);
    return (idx / (1 << W)) + (idx % (1 << W));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_faults_zero();
    for (int i = 0; i < NV; i++) fault[i] = '0;
  endtask

  task automatic set_faults_carry();
    for (int i = 0; i < NV; i++) fault[i] = (sum_of(i) >= 16) ? 5'h10 : 5'h00;
  endtask

  task automatic set_faults_random();
    for (int i = 0; i < NV; i++)
      fault[i] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(1, 31)) : 5'h00;
    fault[$urandom_range(0, NV-1)] = 5'($urandom_range(1, 31));
  endtask

  // Start a sweep on dut1 and follow it until done, an injected reset, or timeout.
  task automatic sweep1(input int restart_at, input int reset_at,
                        output int done_edge, output int busy_bad, output int ab_bad);
    logic [2*W-1:0] v;
    done_edge = -1; busy_bad = 0; ab_bad = 0;
    exp_q.delete();
    for (int i = 0; i < NV; i++) exp_q.push_back((2*W)'(i));
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    check("start_clears_err", 32'(err1), 32'd0);
    check("start_clears_fev", 32'(fev1), 32'd0);
    check("busy_after_start", 32'(busy1), 32'd1);
    for (int e = 1; e <= NV + 40; e++) begin
      if (e == restart_at) start1 = 1'b1;
      if (e == reset_at) rst_n = 1'b0;
      @(posedge clk); #1; start1 = 1'b0;
      if (e == reset_at) begin rst_n = 1'b1; done_edge = -2; break; end
      if (done1) begin done_edge = e; break; end
      if (!busy1) busy_bad++;
      if (exp_q.size() > 0) v = exp_q.pop_front(); else v = '1;
      if ({a1, b1} !== v) ab_bad++;
    end
  endtask

  // Full sweep on dut1 with results compared against the fault table.
  task automatic run_case(input string name, input int restart_at);
    int done_edge, busy_bad, ab_bad, errs, fidx;
    int ea, eb, ez;
    sweep1(restart_at, -1, done_edge, busy_bad, ab_bad);
    errs = 0; fidx = -1;
    for (int i = 0; i < NV; i++)
      if (fault[i] != 0) begin errs++; if (fidx < 0) fidx = i; end
    ea = 0; eb = 0; ez = 0;
    if (fidx >= 0) begin
      ea = fidx / (1 << W); eb = fidx % (1 << W);
      ez = (sum_of(fidx) ^ int'(fault[fidx])) % (1 << (W+1));
    end
    check($sformatf("%s_done_edge", name), 32'(done_edge), 32'(NV + L1 + 1));
    check($sformatf("%s_busy_gap", name), 32'(busy_bad), 32'd0);
    check($sformatf("%s_ab_order", name), 32'(ab_bad), 32'd0);
    check($sformatf("%s_busy_low", name), 32'(busy1), 32'd0);
    check($sformatf("%s_err_count", name), 32'(err1), 32'(errs));
    check($sformatf("%s_pass", name), 32'(pass1), 32'(errs == 0));
    check($sformatf("%s_fev", name), 32'(fev1), 32'(errs != 0));
    check($sformatf("%s_fa", name), 32'(fa1), 32'(ea));
    check($sformatf("%s_fb", name), 32'(fb1), 32'(eb));
    check($sformatf("%s_fz", name), 32'(fz1), 32'(ez));
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("%s_done_held", name), 32'(done1), 32'd1);
  endtask

  task automatic check_zero1(input string name);
    check($sformatf("%s_A", name), 32'(a1), 32'd0);
    check($sformatf("%s_B", name), 32'(b1), 32'd0);
    check($sformatf("%s_busy", name), 32'(busy1), 32'd0);
    check($sformatf("%s_done", name), 32'(done1), 32'd0);
    check($sformatf("%s_pass", name), 32'(pass1), 32'd0);
    check($sformatf("%s_err", name), 32'(err1), 32'd0);
    check($sformatf("%s_fev", name), 32'(fev1), 32'd0);
    check($sformatf("%s_fa", name), 32'(fa1), 32'd0);
    check($sformatf("%s_fb", name), 32'(fb1), 32'd0);
    check($sformatf("%s_fz", name), 32'(fz1), 32'd0);
    check($sformatf("%s_state", name), 32'(st1), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int done_edge, busy_bad, ab_bad, errs2, fidx2, rs;
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
    set_faults_zero();
    repeat (3) @(posedge clk);
    #1;
    check_zero1("reset");
    check("reset_done2", 32'(done2), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    set_faults_zero();
    run_case("ideal", -1);

    set_faults_carry();
    run_case("carry", -1);
    check("carry_err120", 32'(err1), 32'd120);
    check("carry_fa1", 32'(fa1), 32'd1);
    check("carry_fb15", 32'(fb1), 32'd15);
    check("carry_fz0", 32'(fz1), 32'd0);

    set_faults_zero();
    run_case("restart_ideal", -1);

    set_faults_random();
    run_case("rand0", -1);
    set_faults_random();
    run_case("restart_pulse50", 50);
    set_faults_random();
    rs = $urandom_range(2, 250);
    run_case("rand_pulse", rs);

    set_faults_random();
    sweep1(-1, 100, done_edge, busy_bad, ab_bad);
    check_zero1("midrun_reset");
    repeat (2) @(posedge clk);
    #1;
    check("midrun_idle_hold", 32'(st1), 32'd0);
    set_faults_zero();
    run_case("after_reset", -1);

    errs2 = 0; fidx2 = -1;
    for (int k = 0; k < NV; k++) begin
      int nxt;
      nxt = (k + 1 < NV) ? k + 1 : NV - 1;
      if (sum_of(k) != sum_of(nxt)) begin errs2++; if (fidx2 < 0) fidx2 = k; end
    end
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    done_edge = -1;
    for (int e = 1; e <= NV + 40; e++) begin
      @(posedge clk); #1;
      if (done2) begin done_edge = e; break; end
    end
    check("lat2_done_edge", 32'(done_edge), 32'(NV + L2 + 1));
    check("lat2_err_count", 32'(err2), 32'(errs2));
    check("lat2_pass", 32'(pass2), 32'(errs2 == 0));
    check("lat2_fev", 32'(fev2), 32'(errs2 != 0));
    check("lat2_fa", 32'(fa2), 32'(fidx2 / (1 << W)));
    check("lat2_fb", 32'(fb2), 32'(fidx2 % (1 << W)));
    check("lat2_fz", 32'(fz2), 32'(sum_of(fidx2 + 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
